vs4x400_search_ctrl: RTL and testbench



---
 rtl/vs4x400_search_ctrl_if.sv | 46 ++++
 rtl/vs4x400_search_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_vs4x400_search_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vs4x400_search_ctrl_if.sv
// Vector-memory port, host write path and score return bundle
// shared by the search controller and its environment.
interface vs4x400_search_ctrl_if #(
  parameter int ADDR_W  = 10,
  parameter int SCORE_W = 32
);
  logic               host_wr_en;
  logic [ADDR_W-1:0]  host_wr_addr;
  logic [63:0]        host_wr_data;
  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [63:0]        mem_wdata;
  logic               vec_first;
  logic               vec_last;
  logic               score_valid;
  logic [SCORE_W-1:0] score;

  modport slave (
    input  host_wr_en,
    input  host_wr_addr,
    input  host_wr_data,
    input  score_valid,
    input  score,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output vec_first,
    output vec_last
  );

  modport master (
    output host_wr_en,
    output host_wr_addr,
    output host_wr_data,
    output score_valid,
    output score,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  vec_first,
    input  vec_last
  );
endinterface

// File: rtl/vs4x400_search_ctrl.sv
// Nearest-match search sequencer and vector-memory arbiter.
// Optional score-threshold early exit: define VS4X400_EARLY_EXIT_EN.
module vs4x400_search_ctrl #(
  parameter int NUM_VEC         = 256,
  parameter int WORDS_PER_VEC   = 4,
  parameter int ADDR_W          = 10,
  parameter int ID_W            = 8,
  parameter int SCORE_W         = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_areset,
  input  logic               start_search,
`ifdef VS4X400_EARLY_EXIT_EN
  input  logic [SCORE_W-1:0] score_thresh,
`endif
  vs4x400_search_ctrl_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    winner_id,
  output logic [SCORE_W-1:0] max_score,
  output logic               wr_during_search
);

  localparam int TOTAL = NUM_VEC * WORDS_PER_VEC;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int RCV_W = $clog2(NUM_VEC + 1);

  localparam logic [ADDR_W-1:0] WMASK = ADDR_W'(WORDS_PER_VEC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
  localparam logic [RCV_W-1:0] RCV_ALL = RCV_W'(NUM_VEC);
  localparam logic [RCV_W-1:0] RCV_ONE = RCV_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  wcnt;
  logic [OUT_W-1:0]   out_cnt;
  logic [RCV_W-1:0]   rcnt;
  logic               shadow_valid;
  logic [SCORE_W-1:0] shadow_max;
  logic [ID_W-1:0]    shadow_id;

  logic first_w;
  logic last_w;
  logic score_en;
  logic stall;
  logic stop_now;
  logic do_read;
  logic drain_ok;
  logic inc;
  logic dec;

  assign first_w  = (wcnt & WMASK) == '0;
  assign last_w   = (wcnt & WMASK) == WMASK;
  assign score_en = bus.score_valid
                  && (state == ISSUE || state == DRAIN);
  // Outstanding limit only bites on a vector boundary.
  assign stall = bus.host_wr_en
               || (first_w && out_cnt == OUT_MAX);

`ifdef VS4X400_EARLY_EXIT_EN
  logic early_stop;
  logic hit;

  assign hit = score_en && state == ISSUE
             && bus.score >= score_thresh;
  // Finish the vector in progress before stopping.
  assign stop_now = state == ISSUE
                  && (early_stop || hit) && first_w;
  assign drain_ok = out_cnt == '0;
`else
  assign stop_now = 1'b0;
  assign drain_ok = out_cnt == '0 && rcnt == RCV_ALL;
`endif

  assign do_read = state == ISSUE && !stall && !stop_now;
  assign inc     = do_read && last_w;
  assign dec     = score_en;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state            <= IDLE;
      wcnt             <= '0;
      out_cnt          <= '0;
      rcnt             <= '0;
      shadow_valid     <= 1'b0;
      shadow_max       <= '0;
      shadow_id        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      winner_id        <= '0;
      max_score        <= '0;
      wr_during_search <= 1'b0;
      bus.mem_en       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.vec_first    <= 1'b0;
      bus.vec_last     <= 1'b0;
`ifdef VS4X400_EARLY_EXIT_EN
      early_stop       <= 1'b0;
`endif
    end else begin
      done          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.vec_first <= 1'b0;
      bus.vec_last  <= 1'b0;

      if (bus.host_wr_en) begin
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= bus.host_wr_addr;
        bus.mem_wdata <= bus.host_wr_data;
        if (busy) wr_during_search <= 1'b1;
      end else if (do_read) begin
        bus.mem_en    <= 1'b1;
        bus.mem_addr  <= wcnt;
        bus.vec_first <= first_w;
        bus.vec_last  <= last_w;
      end

      unique case (1'b1)
        inc && !dec: out_cnt <= out_cnt + OUT_ONE;
        dec && !inc: out_cnt <= out_cnt - OUT_ONE;
        default: ;
      endcase

      // Strict compare keeps the lowest index on ties.
      if (score_en) begin
        rcnt <= rcnt + RCV_ONE;
        if (!shadow_valid || bus.score > shadow_max) begin
          shadow_valid <= 1'b1;
          shadow_max   <= bus.score;
          shadow_id    <= ID_W'(rcnt);
        end
      end

`ifdef VS4X400_EARLY_EXIT_EN
      if (hit) early_stop <= 1'b1;
`endif

      unique case (state)
        IDLE: begin
          if (start_search) begin
            state            <= ISSUE;
            busy             <= 1'b1;
            wcnt             <= '0;
            rcnt             <= '0;
            out_cnt          <= '0;
            shadow_valid     <= 1'b0;
            wr_during_search <= 1'b0;
`ifdef VS4X400_EARLY_EXIT_EN
            early_stop       <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (stop_now) begin
            state <= DRAIN;
          end else if (do_read) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == LAST_ADDR) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_ok) state <= DONE;
        end
        DONE: begin
          winner_id <= shadow_id;
          max_score <= shadow_max;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vs4x400_search_ctrl.sv
// Randomised bench for vs4x400_search_ctrl with a queue-based
// scoring pipeline and an argmax reference model.
module tb_vs4x400_search_ctrl;
  localparam int NV  = 256;
  localparam int WPV = 4;
  localparam int TOT = NV * WPV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  winner_id;
  logic [31:0] max_score;
  logic        wds;
`ifdef VS4X400_EARLY_EXIT_EN
  logic [31:0] thresh = 32'hFFFF_FFFF;
`endif

  vs4x400_search_ctrl_if bus ();

  vs4x400_search_ctrl dut (
    .s_axi_aclk       (clk),
    .s_axi_areset     (rst),
    .start_search     (start),
`ifdef VS4X400_EARLY_EXIT_EN
    .score_thresh     (thresh),
`endif
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .winner_id        (winner_id),
    .max_score        (max_score),
    .wr_during_search (wds)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 2;
  logic [31:0] tab [NV];
  int dq [$];
  logic [31:0] sq [$];
  int iss_q [$];
  int exp_addr, seq_err, vf_err, split_err, rd_cnt;
  int done_cnt, done_cyc, out_now, out_max;
  int wr_cyc, last_rd_cyc, base_lat;
  logic [9:0]  wr_addr_seen;
  logic [63:0] wr_data_seen;
  logic pipe_drv = 1'b0;
  int last_id = 0;
  logic [31:0] last_mx = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Port monitor and scoring pipeline: scores return in issue order
  // 'lat' cycles after the last word of each vector is read.
  initial begin
    bus.score_valid = 1'b0;
    bus.score = '0;
    forever begin
      @(negedge clk);
      if (bus.score_valid && pipe_drv) out_now--;
      if (rst) begin
        dq.delete();
        sq.delete();
        out_now = 0;
        pipe_drv = 1'b0;
        bus.score_valid = 1'b0;
      end else begin
        if (bus.mem_en && !bus.mem_we) begin
          int a;
          a = int'(bus.mem_addr);
          if (a != exp_addr) seq_err++;
          if (bus.vec_first !== (a % WPV == 0)) vf_err++;
          if (bus.vec_last !== (a % WPV == WPV - 1)) vf_err++;
          if (a % WPV != 0 && last_rd_cyc != cyc - 1) split_err++;
          last_rd_cyc = cyc;
          exp_addr = a + 1;
          rd_cnt++;
          if (a % WPV == WPV - 1) begin
            iss_q.push_back(a / WPV);
            dq.push_back(cyc + lat);
            sq.push_back(tab[a / WPV]);
            out_now++;
            if (out_now > out_max) out_max = out_now;
          end
        end
        if (bus.mem_en && bus.mem_we) begin
          wr_cyc = cyc;
          wr_addr_seen = bus.mem_addr;
          wr_data_seen = bus.mem_wdata;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        pipe_drv = 1'b0;
        bus.score_valid = 1'b0;
        if (dq.size() > 0 && dq[0] <= cyc) begin
          bus.score_valid = 1'b1;
          bus.score = sq.pop_front();
          void'(dq.pop_front());
          pipe_drv = 1'b1;
        end
      end
    end
  end

  task automatic clear_obs();
    exp_addr = 0; seq_err = 0; vf_err = 0; split_err = 0;
    rd_cnt = 0; done_cnt = 0; done_cyc = 0; out_max = 0;
    wr_cyc = -1; last_rd_cyc = -10;
    iss_q.delete();
  endtask

  task automatic pulse_start(output int sc);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 sc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    ok = (done_cnt != 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Argmax over the whole table, lowest index wins ties.
  task automatic ref_full(output int id, output logic [31:0] mx);
    id = 0;
    mx = tab[0];
    for (int i = 1; i < NV; i++)
      if (tab[i] > mx) begin
        mx = tab[i];
        id = i;
      end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.host_wr_en = 1'b0;
    bus.host_wr_addr = '0;
    bus.host_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d want=0", done); end
    checks++; if (winner_id !== 8'd0) begin failures++; $display("FAIL reset_winner got=%0d want=0", winner_id); end
    checks++; if (max_score !== 32'd0) begin failures++; $display("FAIL reset_max got=%0d want=0", max_score); end
    checks++; if (wds !== 1'b0) begin failures++; $display("FAIL reset_wds got=%0d want=0", wds); end
    checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%0d want=0", bus.mem_en); end
  endtask

  task automatic test_full_index();
    int sc;
    bit ok;
    for (int i = 0; i < NV; i++) tab[i] = i;
    lat = 2;
    clear_obs();
    pulse_start(sc);
    wait_done(ok);
    base_lat = done_cyc - sc;
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=0 want=1"); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL full_done_count got=%0d want=1", done_cnt); end
    checks++; if (rd_cnt != TOT) begin failures++; $display("FAIL full_reads got=%0d want=%0d", rd_cnt, TOT); end
    checks++; if (seq_err != 0) begin failures++; $display("FAIL full_order got=%0d want=0", seq_err); end
    checks++; if (vf_err != 0) begin failures++; $display("FAIL full_framing got=%0d want=0", vf_err); end
    checks++; if (winner_id !== 8'd255) begin failures++; $display("FAIL full_winner got=%0d want=255", winner_id); end
    checks++; if (max_score !== 32'd255) begin failures++; $display("FAIL full_max got=%0d want=255", max_score); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy got=%0d want=0", busy); end
    last_id = 255;
    last_mx = 255;
  endtask

  task automatic test_ties();
    int sc;
    bit ok;
    for (int i = 0; i < NV; i++) tab[i] = 32'h10;
    lat = 3;
    clear_obs();
    pulse_start(sc);
    wait_done(ok);
    checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL tie_done got=%0d want=1", done_cnt); end
    checks++; if (winner_id !== 8'd0) begin failures++; $display("FAIL tie_winner got=%0d want=0", winner_id); end
    checks++; if (max_score !== 32'h10) begin failures++; $display("FAIL tie_max got=%0h want=10", max_score); end
    last_id = 0;
    last_mx = 32'h10;
  endtask

  task automatic test_random();
    int sc, eid;
    logic [31:0] emx;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NV; i++)
        tab[i] = (it % 2 == 0) ? $urandom_range(0, 63) : $urandom;
      lat = $urandom_range(1, 12);
      ref_full(eid, emx);
      clear_obs();
      pulse_start(sc);
      wait_done(ok);
      checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL rand%0d_done got=%0d want=1", it, done_cnt); end
      checks++; if (seq_err != 0 || rd_cnt != TOT) begin failures++; $display("FAIL rand%0d_reads got=%0d/%0d want=%0d/0", it, rd_cnt, seq_err, TOT); end
      checks++; if (winner_id !== 8'(eid)) begin failures++; $display("FAIL rand%0d_winner got=%0d want=%0d", it, winner_id, eid); end
      checks++; if (max_score !== emx) begin failures++; $display("FAIL rand%0d_max got=%0h want=%0h", it, max_score, emx); end
      last_id = eid;
      last_mx = emx;
    end
  endtask

  task automatic test_host_write();
    int sc, k, eid;
    logic [31:0] emx;
    logic [63:0] wd;
    bit ok;
    for (int i = 0; i < NV; i++) tab[i] = $urandom;
    lat = 2;
    ref_full(eid, emx);
    wd = {$urandom, $urandom};
    clear_obs();
    pulse_start(sc);
    repeat (99) @(posedge clk);
    #1 k = cyc;
    bus.host_wr_en = 1'b1;
    bus.host_wr_addr = 10'h155;
    bus.host_wr_data = wd;
    @(posedge clk);
    #1 bus.host_wr_en = 1'b0;
    checks++; if (winner_id !== 8'(last_id) || max_score !== last_mx) begin failures++; $display("FAIL hw_hold got=%0d/%0h want=%0d/%0h", winner_id, max_score, last_id, last_mx); end
    wait_done(ok);
    checks++; if (wr_cyc != k + 1) begin failures++; $display("FAIL hw_latency got=%0d want=%0d", wr_cyc, k + 1); end
    checks++; if (wr_addr_seen !== 10'h155 || wr_data_seen !== wd) begin failures++; $display("FAIL hw_payload got=%0h/%0h want=155/%0h", wr_addr_seen, wr_data_seen, wd); end
    checks++; if (seq_err != 0 || rd_cnt != TOT) begin failures++; $display("FAIL hw_reads got=%0d/%0d want=%0d/0", rd_cnt, seq_err, TOT); end
    checks++; if (wds !== 1'b1) begin failures++; $display("FAIL hw_flag got=%0d want=1", wds); end
    checks++; if (!ok || done_cyc - sc != base_lat + 1) begin failures++; $display("FAIL hw_done_time got=%0d want=%0d", done_cyc - sc, base_lat + 1); end
    checks++; if (winner_id !== 8'(eid) || max_score !== emx) begin failures++; $display("FAIL hw_result got=%0d/%0h want=%0d/%0h", winner_id, max_score, eid, emx); end
    last_id = eid;
    last_mx = emx;
  endtask

  task automatic test_backpressure();
    int sc, eid;
    logic [31:0] emx;
    bit ok;
    for (int i = 0; i < NV; i++) tab[i] = $urandom;
    lat = 40;
    ref_full(eid, emx);
    clear_obs();
    pulse_start(sc);
    wait_done(ok);
    checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
    checks++; if (out_max != 8) begin failures++; $display("FAIL bp_outstanding got=%0d want=8", out_max); end
    checks++; if (split_err != 0) begin failures++; $display("FAIL bp_split got=%0d want=0", split_err); end
    checks++; if (seq_err != 0 || rd_cnt != TOT) begin failures++; $display("FAIL bp_reads got=%0d/%0d want=%0d/0", rd_cnt, seq_err, TOT); end
    checks++; if (wds !== 1'b0) begin failures++; $display("FAIL bp_flag_clear got=%0d want=0", wds); end
    checks++; if (winner_id !== 8'(eid) || max_score !== emx) begin failures++; $display("FAIL bp_result got=%0d/%0h want=%0d/%0h", winner_id, max_score, eid, emx); end
    last_id = eid;
    last_mx = emx;
  endtask

  task automatic test_restart_reset();
    int sc, n, eid;
    logic [31:0] emx;
    bit ok;
    for (int i = 0; i < NV; i++) tab[i] = $urandom;
    lat = 2;
    clear_obs();
    pulse_start(sc);
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (rd_cnt < 500 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++; if (rd_cnt < 500) begin failures++; $display("FAIL rr_reach500 got=%0d want=500", rd_cnt); end
    checks++; if (seq_err != 0) begin failures++; $display("FAIL rr_restart_ignored got=%0d want=0", seq_err); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_async_busy got=%0d want=0", busy); end
    checks++; if (winner_id !== 8'd0 || max_score !== 32'd0) begin failures++; $display("FAIL rr_async_result got=%0d/%0h want=0/0", winner_id, max_score); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NV; i++) tab[i] = $urandom_range(0, 1000);
    ref_full(eid, emx);
    clear_obs();
    pulse_start(sc);
    wait_done(ok);
    checks++; if (!ok || done_cnt != 1 || rd_cnt != TOT) begin failures++; $display("FAIL rr_rerun got=%0d/%0d want=1/%0d", done_cnt, rd_cnt, TOT); end
    checks++; if (winner_id !== 8'(eid) || max_score !== emx) begin failures++; $display("FAIL rr_result got=%0d/%0h want=%0d/%0h", winner_id, max_score, eid, emx); end
  endtask

`ifdef VS4X400_EARLY_EXIT_EN
  task automatic test_early_exit();
    int sc, eid;
    logic [31:0] emx;
    bit ok;
    for (int i = 0; i < NV; i++) tab[i] = $urandom_range(0, 32'h7F);
    tab[37] = 32'h90;
    thresh = 32'h80;
    lat = 2;
    clear_obs();
    pulse_start(sc);
    wait_done(ok);
    eid = iss_q[0];
    emx = tab[iss_q[0]];
    foreach (iss_q[i])
      if (tab[iss_q[i]] > emx) begin
        emx = tab[iss_q[i]];
        eid = iss_q[i];
      end
    checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL ee_done got=%0d want=1", done_cnt); end
    checks++; if (rd_cnt >= TOT || rd_cnt % WPV != 0 || iss_q.size() < 38) begin failures++; $display("FAIL ee_reads got=%0d want<%0d", rd_cnt, TOT); end
    checks++; if (winner_id !== 8'(eid) || max_score !== emx) begin failures++; $display("FAIL ee_result got=%0d/%0h want=%0d/%0h", winner_id, max_score, eid, emx); end
    thresh = 32'hFFFF_FFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_full_index();
    test_ties();
    test_random();
    test_host_write();
    test_backpressure();
    test_restart_reset();
`ifdef VS4X400_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
